// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch handshake between pc_gen (master) and the IF stage (slave)
//   pc_valid_o  pc_o holds a fetch request
//   pc_ready_i  IF accepts pc_o this cycle
//   pc_o        current fetch PC
interface pc_gen_if #(parameter int XLEN = 64);
  logic            pc_valid_o;
  logic            pc_ready_i;
  logic [XLEN-1:0] pc_o;
  modport master (output pc_valid_o, output pc_o, input pc_ready_i);
  modport slave  (input pc_valid_o, input pc_o, output pc_ready_i);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with boot/run/halt FSM, trap > EX > sequential next-PC
//   clock, reset (async active-low); fif: fetch handshake (pc_gen_if.master)
//   ex_*/branch_i/b_flag_i/jump_i/offset_i/rs1_i: EX redirect; trap_i/trap_pc_i: trap redirect
//   halt_i: sticky stop; misalign_o/misalign_addr_o: misaligned EX target report
//   PC_GEN_PERF_CNT_EN adds fetch_cnt_o / redirect_cnt_o
module pc_gen #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          C_EXT    = 0,
  parameter int          SEQ_STEP = 4
) (
  input  logic            clock,
  input  logic            reset,
  pc_gen_if.master        fif,
  input  logic            ex_valid_i,
  input  logic            branch_i,
  input  logic            b_flag_i,
  input  logic [1:0]      jump_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            halt_i,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
`ifdef PC_GEN_PERF_CNT_EN
  ,
  output logic [63:0]     fetch_cnt_o,
  output logic [63:0]     redirect_cnt_o
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_mis;
  logic [XLEN-1:0] r_mis_addr;
  logic            w_jalr;
  logic            w_ex_take;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic            w_mis;
  logic            w_fire;
  logic            w_act;
  assign w_jalr    = jump_i == 2'b01;
  assign w_ex_take = ex_valid_i & ((branch_i & b_flag_i) | w_jalr | (jump_i == 2'b10));
  assign w_sum     = offset_i + (w_jalr ? rs1_i : ex_pc_i);
  assign w_target  = {w_sum[XLEN-1:1], w_sum[0] & ~w_jalr};
  assign w_mis     = (C_EXT == 0) && w_target[1];
  assign w_fire    = r_valid & fif.pc_ready_i;
  // redirects and sequential steps only act in RUN when not halting this cycle
  assign w_act     = (r_state == RUN) & ~halt_i;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC[XLEN-1:0];
      r_valid    <= 1'b0;
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        RUN: begin
          if (halt_i) begin
            r_state <= HALT;
            r_valid <= 1'b0;
          end else if (trap_i) r_pc <= trap_pc_i;
          else if (w_ex_take && !w_mis) r_pc <= w_target;
          else if (w_fire) r_pc <= r_pc + XLEN'(SEQ_STEP);
          // misaligned EX target: report it, redirect suppressed above
          if (w_act && !trap_i && w_ex_take && w_mis) begin
            r_mis      <= 1'b1;
            r_mis_addr <= w_target;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end
  assign fif.pc_o       = r_pc;
  assign fif.pc_valid_o = r_valid;
  assign misalign_o      = r_mis;
  assign misalign_addr_o = r_mis_addr;
`ifdef PC_GEN_PERF_CNT_EN
  logic [63:0] r_fetch_cnt;
  logic [63:0] r_redir_cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_fire) r_fetch_cnt <= r_fetch_cnt + 64'd1;
      if (w_act && (trap_i || (w_ex_take && !w_mis))) r_redir_cnt <= r_redir_cnt + 64'd1;
    end
  end
  assign fetch_cnt_o    = r_fetch_cnt;
  assign redirect_cnt_o = r_redir_cnt;
`endif
endmodule
